// File: rtl/bnn_input_loader.sv
// Pixel-stream loader for the binarised CNN: thresholds each pixel into a packed bit image,
// lets the network settle after the last pixel, then holds the frame until acknowledged.
module bnn_input_loader #(
  parameter int IMG_W         = 28,
  parameter int IMG_H         = 28,
  parameter int PIX_W         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  input  logic [PIX_W-1:0]                      threshold_i,
  input  logic                                  pix_valid_i,
  input  logic [PIX_W-1:0]                      pix_data_i,
  output logic                                  pix_ready_o,
  output logic [0:0][IMG_H-1:0][IMG_W-1:0]      layer_o,
  output logic                                  frame_valid_o,
  input  logic                                  frame_ack_i,
  output logic                                  busy_o,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]      pix_count_o
);

  // state  | meaning
  // IDLE   | waiting for start_i, previous image retained
  // LOAD   | accepting pixels in raster order
  // SETTLE | image complete, network output resolving
  // HOLD   | image frozen, frame_valid_o until frame_ack_i
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NPIX - 1);
  localparam logic [COL_W-1:0] LAST_COL    = COL_W'(IMG_W - 1);
  localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [PIX_W-1:0] thr_q;
  logic [7:0]       settle_cnt_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  logic xfer, last_xfer, ack_acc, start_acc;

  // start_i wins over a pixel presented in the same LOAD cycle, so that pixel is dropped
  always_comb begin
    xfer      = (state_q == S_LOAD) && pix_valid_i && pix_ready_o && !start_i;
    last_xfer = xfer && (pix_count_o == LAST_IDX);
    ack_acc   = (state_q == S_HOLD) && frame_valid_o && frame_ack_i;
    start_acc = start_i && ((state_q == S_IDLE) || (state_q == S_LOAD) || ack_acc);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (start_i)        state_d = S_LOAD;
        else if (last_xfer) state_d = (SETTLE_CYCLES == 0) ? S_HOLD : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q <= 8'd1) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ack_acc) state_d = start_i ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // frame_valid_o trails HOLD entry by one edge, giving SETTLE_CYCLES+1 edges after the last pixel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      pix_ready_o   <= 1'b0;
      busy_o        <= 1'b0;
      frame_valid_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_ready_o   <= (state_d == S_LOAD);
      busy_o        <= (state_d == S_LOAD) || (state_d == S_SETTLE);
      frame_valid_o <= (state_q == S_HOLD) && (state_d == S_HOLD);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      thr_q       <= '0;
      layer_o     <= '0;
      pix_count_o <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else if (start_acc) begin
      thr_q       <= threshold_i;
      layer_o     <= '0;
      pix_count_o <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else if (xfer) begin
      layer_o[0][row_q][col_q] <= (pix_data_i >= thr_q);
      pix_count_o              <= pix_count_o + CNT_W'(1);
      if (col_q == LAST_COL) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_cnt_q <= '0;
    end else if (last_xfer) begin
      settle_cnt_q <= SETTLE_INIT;
    end else if ((state_q == S_SETTLE) && (settle_cnt_q != 8'd0)) begin
      settle_cnt_q <= settle_cnt_q - 8'd1;
    end
  end

endmodule

// File: tb/tb_bnn_input_loader.sv
// Scoreboard bench for bnn_input_loader: a SETTLE_CYCLES=4 instance and a SETTLE_CYCLES=0 instance.
module tb_bnn_input_loader;
  localparam int W = 28;
  localparam int H = 28;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   start = 0, pv = 0, ack = 0;
  logic [7:0]             thr = 0, pd = 0;
  logic                   rdy, fv, busy;
  logic [9:0]             cnt;
  logic [0:0][H-1:0][W-1:0] layer;
  logic [N-1:0]           flat;

  logic                   start_z = 0, pv_z = 0, ack_z = 0;
  logic [7:0]             thr_z = 0, pd_z = 0;
  logic                   rdy_z, fv_z, busy_z;
  logic [9:0]             cnt_z;
  logic [0:0][H-1:0][W-1:0] layer_z;
  logic [N-1:0]           flat_z;

  assign flat   = layer;
  assign flat_z = layer_z;

  bnn_input_loader #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .SETTLE_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .threshold_i(thr),
    .pix_valid_i(pv), .pix_data_i(pd), .pix_ready_o(rdy), .layer_o(layer),
    .frame_valid_o(fv), .frame_ack_i(ack), .busy_o(busy), .pix_count_o(cnt));

  bnn_input_loader #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .SETTLE_CYCLES(0)) dut_z (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_z), .threshold_i(thr_z),
    .pix_valid_i(pv_z), .pix_data_i(pd_z), .pix_ready_o(rdy_z), .layer_o(layer_z),
    .frame_valid_o(fv_z), .frame_ack_i(ack_z), .busy_o(busy_z), .pix_count_o(cnt_z));

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  // Streams n transfers into the selected DUT, pushing the model's expected bit per transfer.
  task automatic stream(input int sel, input int mode, input int n, input int duty,
                        input logic [7:0] thr_exp, output int sent, output int cycles);
    logic v, x;
    logic [7:0] d;
    sent = 0;
    cycles = 0;
    while (sent < n && cycles < 5000) begin
      v = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      case (mode)
        0:       d = (sent % 2 == 0) ? 8'd255 : 8'd0;
        1:       d = (sent == 0) ? 8'd100 : (sent == 1) ? 8'd99 : 8'd0;
        default: d = 8'($urandom_range(0, 255));
      endcase
      if (mode == 1 && sent == 400) thr = 8'd0;
      if (sel == 0) begin pv = v; pd = d; x = v & rdy; end
      else begin pv_z = v; pd_z = d; x = v & rdy_z; end
      @(posedge clk); #1;
      cycles++;
      if (x) begin
        exp_q.push_back(d >= thr_exp);
        sent++;
      end
    end
    pv = 0;
    pv_z = 0;
  endtask

  task automatic wait_fv(input int sel, output int edges);
    edges = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if ((sel == 0) ? fv : fv_z) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic pop_expected(output logic [N-1:0] v);
    for (int n = 0; n < N; n++) v[n] = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse(input logic s, input logic a, input logic [7:0] t);
    start = s; ack = a; thr = t;
    @(posedge clk); #1;
    start = 0; ack = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rdy, fv, busy} !== 3'b000 || cnt !== 10'd0 || flat !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b fv=%b busy=%b cnt=%0d expected all zero", rdy, fv, busy, cnt);
    end
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b expected 0 0", rdy, busy);
    end
  endtask

  task automatic test_basic();
    int sent, cyc, edges;
    logic [N-1:0] e;
    pulse(1, 0, 8'd128);
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b1 || cnt !== 10'd0) begin
      errors++;
      $display("FAIL basic_start: rdy=%b busy=%b cnt=%0d expected 1 1 0", rdy, busy, cnt);
    end
    stream(0, 0, N, 100, 8'd128, sent, cyc);
    checks++;
    if (sent != N || cyc != N) begin
      errors++;
      $display("FAIL basic_throughput: %0d transfers in %0d cycles expected %0d in %0d", sent, cyc, N, N);
    end
    wait_fv(0, edges);
    checks++;
    if (edges != 5) begin
      errors++;
      $display("FAIL basic_settle: frame_valid after %0d edges expected 5", edges);
    end
    checks++;
    if (cnt !== 10'd784 || layer[0][0][0] !== 1'b1 || layer[0][0][1] !== 1'b0) begin
      errors++;
      $display("FAIL basic_count_bits: cnt=%0d b00=%b b01=%b expected 784 1 0", cnt, layer[0][0][0], layer[0][0][1]);
    end
    pop_expected(e);
    checks++;
    if (flat !== e) begin
      errors++;
      $display("FAIL basic_image: %0d bits differ from model", $countones(flat ^ e));
    end
    pulse(0, 1, 8'd0);
    checks++;
    if (fv !== 1'b0 || busy !== 1'b0 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: fv=%b busy=%b rdy=%b expected 0 0 0", fv, busy, rdy);
    end
  endtask

  task automatic test_threshold();
    int sent, cyc, edges;
    logic [N-1:0] e;
    pulse(1, 0, 8'd100);
    stream(0, 1, N, 100, 8'd100, sent, cyc);
    wait_fv(0, edges);
    checks++;
    if (edges != 5 || layer[0][0][0] !== 1'b1 || layer[0][0][1] !== 1'b0) begin
      errors++;
      $display("FAIL thr_boundary: edges=%0d b00=%b b01=%b expected 5 1 0", edges, layer[0][0][0], layer[0][0][1]);
    end
    pop_expected(e);
    checks++;
    if (flat !== e) begin
      errors++;
      $display("FAIL thr_image: %0d bits differ from model", $countones(flat ^ e));
    end
    pulse(0, 1, 8'd0);
  endtask

  task automatic test_backpressure();
    int sent, cyc, sent2, edges;
    logic [N-1:0] e;
    bit last_exp;
    pulse(1, 0, 8'd77);
    stream(0, 2, 300, 30, 8'd77, sent, cyc);
    checks++;
    if (cnt !== 10'(sent) || sent != 300) begin
      errors++;
      $display("FAIL bp_midcount: cnt=%0d expected %0d", cnt, sent);
    end
    stream(0, 2, N - 300, 30, 8'd77, sent2, cyc);
    last_exp = exp_q[exp_q.size() - 1];
    wait_fv(0, edges);
    checks++;
    if (edges != 5 || cnt !== 10'd784 || layer[0][27][27] !== last_exp) begin
      errors++;
      $display("FAIL bp_last: edges=%0d cnt=%0d b2727=%b expected 5 784 %b", edges, cnt, layer[0][27][27], last_exp);
    end
    pop_expected(e);
    checks++;
    if (flat !== e) begin
      errors++;
      $display("FAIL bp_image: %0d bits differ from model", $countones(flat ^ e));
    end
    pulse(0, 1, 8'd0);
  endtask

  task automatic test_abort();
    int sent, cyc, edges;
    logic [N-1:0] e;
    pulse(1, 0, 8'd200);
    stream(0, 2, 400, 100, 8'd200, sent, cyc);
    pv = 1; pd = 8'd255;
    pulse(1, 0, 8'd50);
    pv = 0;
    exp_q.delete();
    checks++;
    if (cnt !== 10'd0 || flat !== '0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL abort_clear: cnt=%0d ones=%0d rdy=%b expected 0 0 1", cnt, $countones(flat), rdy);
    end
    stream(0, 2, N - 1, 60, 8'd50, sent, cyc);
    @(posedge clk); #1;
    checks++;
    if (fv !== 1'b0 || busy !== 1'b1 || cnt !== 10'd783) begin
      errors++;
      $display("FAIL abort_partial: fv=%b busy=%b cnt=%0d expected 0 1 783", fv, busy, cnt);
    end
    stream(0, 2, 1, 100, 8'd50, sent, cyc);
    wait_fv(0, edges);
    pop_expected(e);
    checks++;
    if (edges != 5 || flat !== e) begin
      errors++;
      $display("FAIL abort_image: edges=%0d diffbits=%0d expected 5 0", edges, $countones(flat ^ e));
    end
    pulse(0, 1, 8'd0);
  endtask

  task automatic test_handshake();
    int sent, cyc, edges;
    logic [N-1:0] snap, e;
    bit stable;
    pulse(1, 0, 8'd128);
    stream(0, 0, N, 100, 8'd128, sent, cyc);
    wait_fv(0, edges);
    pop_expected(e);
    snap = flat;
    stable = 1;
    for (int k = 0; k < 20; k++) begin
      start = (k == 10);
      thr = 8'd3;
      @(posedge clk); #1;
      start = 0;
      if (fv !== 1'b1 || flat !== snap) stable = 0;
    end
    checks++;
    if (!stable || snap !== e) begin
      errors++;
      $display("FAIL hold_stable: stable=%0d diffbits=%0d expected 1 0", stable, $countones(snap ^ e));
    end
    pulse(1, 1, 8'd9);
    checks++;
    if (fv !== 1'b0 || flat !== '0 || rdy !== 1'b1 || busy !== 1'b1 || cnt !== 10'd0) begin
      errors++;
      $display("FAIL ack_start: fv=%b ones=%0d rdy=%b busy=%b cnt=%0d expected 0 0 1 1 0",
               fv, $countones(flat), rdy, busy, cnt);
    end
  endtask

  task automatic test_async_reset();
    int sent, cyc, edges;
    stream(0, 2, N, 100, 8'd9, sent, cyc);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || fv !== 1'b0 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL settle_state: busy=%b fv=%b rdy=%b expected 1 0 0", busy, fv, rdy);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({rdy, fv, busy} !== 3'b000 || cnt !== 10'd0 || flat !== '0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b fv=%b busy=%b cnt=%0d ones=%0d expected all zero",
               rdy, fv, busy, cnt, $countones(flat));
    end
    @(negedge clk);
    rst_n = 1;
    wait_fv(0, edges);
    checks++;
    if (edges != -1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_partial_frame: fv after %0d edges busy=%b expected never 0", edges, busy);
    end
  endtask

  task automatic test_settle0();
    int sent, cyc, edges;
    logic [N-1:0] e;
    start_z = 1; thr_z = 8'd128;
    @(posedge clk); #1;
    start_z = 0;
    stream(1, 2, N, 100, 8'd128, sent, cyc);
    wait_fv(1, edges);
    checks++;
    if (edges != 1 || cnt_z !== 10'd784) begin
      errors++;
      $display("FAIL settle0_timing: edges=%0d cnt=%0d expected 1 784", edges, cnt_z);
    end
    pop_expected(e);
    checks++;
    if (flat_z !== e) begin
      errors++;
      $display("FAIL settle0_image: %0d bits differ from model", $countones(flat_z ^ e));
    end
    ack_z = 1;
    @(posedge clk); #1;
    ack_z = 0;
    checks++;
    if (fv_z !== 1'b0) begin
      errors++;
      $display("FAIL settle0_ack: fv=%b expected 0", fv_z);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_backpressure();
    test_abort();
    test_handshake();
    test_async_reset();
    test_settle0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
